// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR-driven request scheduler.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 4;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned CNT_W  = 16;

  localparam logic [LFSR_W-1:0] LFSR_RESET_SEED = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // One Fibonacci step: shift left, feedback q3^q2 into q0 (period 15).
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

endpackage

// File: rtl/lfsr_sched_step.sv
// 4-bit Fibonacci LFSR register with seed load and step enable.
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              en,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LFSR_RESET_SEED;
    end else if (load) begin
      state <= load_val;
    end else if (en) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/lfsr_sched.sv
// Round-robin scheduler: each grant advances a shared LFSR STEPS times and
// returns the resulting state. Optional response counter: LFSR_SCHED_STATS_EN.
module lfsr_sched
  import lfsr_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned STEPS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic              seed_we,
  input  logic [LFSR_W-1:0] seed_data,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [LFSR_W-1:0] rsp_data,
  output logic [ID_W-1:0]   rsp_id,
  output logic              busy,
  output logic [CNT_W-1:0]  gnt_count
);

  localparam int unsigned       STEP_W    = 4;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

  state_e              state;
  state_e              state_nxt;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     ptr_nxt;
  logic [STEP_W-1:0]   step;
  logic [STEP_W-1:0]   step_nxt;
  logic [NREQ-1:0]     gnt_nxt;
  logic [ID_W-1:0]     id_nxt;
  logic                valid_nxt;
  logic [LFSR_W-1:0]   data_nxt;

  logic [LFSR_W-1:0]   lfsr;
  logic [LFSR_W-1:0]   seed_val;
  logic                lfsr_load;
  logic                lfsr_en;
  logic                accept;

  logic [2*NREQ-1:0]   req_dbl;
  logic [NREQ-1:0]     req_rot;
  logic                any_req;
  logic [ID_W-1:0]     win;
  logic [NREQ-1:0]     win_onehot;

  // A zero seed would lock the LFSR, so it is replaced by the reset seed.
  assign seed_val = (seed_data == '0) ? LFSR_RESET_SEED : seed_data;
  assign accept   = rsp_valid && rsp_ready;

  lfsr_step u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed_val),
    .en       (lfsr_en),
    .state    (lfsr)
  );

  // Round-robin arbiter: rotate so ptr sits at bit 0, take the first set bit.
  always_comb begin
    req_dbl = {req, req};
    req_rot = NREQ'(req_dbl >> ptr);
    any_req = 1'b0;
    win     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any_req && req_rot[i]) begin
        any_req = 1'b1;
        win     = ID_W'((32'(ptr) + i) % NREQ);
      end
    end
    win_onehot = NREQ'(1) << win;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    step_nxt  = step;
    gnt_nxt   = gnt;
    id_nxt    = rsp_id;
    valid_nxt = rsp_valid;
    data_nxt  = rsp_data;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (seed_we) begin
          lfsr_load = 1'b1;
        end else if (any_req) begin
          gnt_nxt   = win_onehot;
          id_nxt    = win;
          step_nxt  = '0;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        lfsr_en = 1'b1;
        if (step == STEP_LAST) begin
          state_nxt = ST_RESP;
          valid_nxt = 1'b1;
          data_nxt  = lfsr_next(lfsr);
        end else begin
          step_nxt = step + STEP_W'(1);
        end
      end
      ST_RESP: begin
        if (accept) begin
          state_nxt = ST_IDLE;
          valid_nxt = 1'b0;
          gnt_nxt   = '0;
          ptr_nxt   = ID_W'((32'(rsp_id) + 1) % NREQ);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      step      <= '0;
      gnt       <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= LFSR_RESET_SEED;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      step      <= step_nxt;
      gnt       <= gnt_nxt;
      rsp_id    <= id_nxt;
      rsp_valid <= valid_nxt;
      rsp_data  <= data_nxt;
      busy      <= (state_nxt != ST_IDLE);
    end
  end

`ifdef LFSR_SCHED_STATS_EN
  logic [CNT_W-1:0] count;

  // Accepted-response counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (accept) begin
      count <= count + CNT_W'(1);
    end
  end

  assign gnt_count = count;
`else
  assign gnt_count = '0;
`endif

endmodule
